// File: rtl/bridge_ioctl_tx.sv
// bridge_ioctl_tx
//   Transmitter side of the ioctl download stream. 32-bit words written by the
//   APF bridge are queued in a small FIFO, then serialised big-endian into the
//   byte-wide ioctl_* stream consumed by rom_loader. Byte strobes are spaced by
//   at least WRITE_GAP idle cycles, and ioctl_wait stalls the next byte.
//
// Ports
//   CLK, RSTn             clock (rising edge), asynchronous active-low reset
//   dl_start / dl_end     1-cycle pulses that open / close a download
//   bridge_index          dataslot number, captured into ioctl_index on start
//   bridge_wr/addr/data   one word write (byte address, bits [1:0] ignored)
//   fifo_full             FIFO holds FIFO_DEPTH words (registered)
//   overflow              sticky: a write was dropped because the FIFO was full
//   ioctl_download        download in progress
//   ioctl_index           captured index
//   ioctl_wr              1-cycle byte strobe
//   ioctl_addr/ioctl_dout byte address/data, held until the next strobe
//   ioctl_wait            receiver stall request

module bridge_ioctl_tx #(
  parameter int FIFO_DEPTH = 16,
  parameter int WRITE_GAP  = 4,
  parameter int ADDR_W     = 25
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic              dl_start,
  input  logic              dl_end,
  input  logic [7:0]        bridge_index,
  input  logic              bridge_wr,
  input  logic [31:0]       bridge_addr,
  input  logic [31:0]       bridge_data,
  output logic              fifo_full,
  output logic              overflow,
  output logic              ioctl_download,
  output logic [7:0]        ioctl_index,
  output logic              ioctl_wr,
  output logic [ADDR_W-1:0] ioctl_addr,
  output logic [7:0]        ioctl_dout,
  input  logic              ioctl_wait
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int WA_W  = ADDR_W - 2;
  localparam int ENT_W = WA_W + 32;
  localparam int GAP_W = $clog2(WRITE_GAP + 1);

  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(FIFO_DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [GAP_W-1:0] GAP_INIT = GAP_W'(WRITE_GAP);
  localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);

  typedef enum logic [1:0] {S_EMPTY, S_READY, S_GAP} state_t;

  // FIFO storage and pointers
  logic [ENT_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   count_q, count_d;
  logic             full_q;

  // Download control
  logic             download_q, end_pending_q, overflow_q;
  logic [7:0]       index_q;

  // Serialiser
  state_t           state_q;
  logic [GAP_W-1:0] gap_q;
  logic [WA_W-1:0]  word_addr_q;
  logic [31:0]      word_data_q;
  logic [1:0]       byte_cnt_q;
  logic             have_word_q;
  logic             wr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]       dout_q;

  logic             accept_window, push, drop, pop, issue, finish;
  logic [ENT_W-1:0] pop_entry;

  // Writes are accepted only while a download is open and no end has been
  // requested, including the very cycle dl_end arrives.
  assign accept_window = download_q && !end_pending_q && !dl_end;
  assign push          = bridge_wr && accept_window && !full_q;
  assign drop          = bridge_wr && accept_window && full_q;

  // A word is popped when the shift register has nothing left to send: either
  // idle, or in the gap after the 4th byte (prefetch hides word boundaries).
  assign pop   = (count_q != '0) &&
                 ((state_q == S_EMPTY) || ((state_q == S_GAP) && !have_word_q));
  assign issue = (state_q == S_READY) && !ioctl_wait && (gap_q == '0);
  assign finish = end_pending_q && (count_q == '0) &&
                  (state_q == S_EMPTY) && (gap_q == '0);

  assign pop_entry = mem_q[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CNT_ONE;
    end else if (pop && !push) begin
      count_d = count_q - CNT_ONE;
    end
  end

  // Storage carries no reset; validity is tracked by the pointers.
  always_ff @(posedge CLK) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {bridge_addr[ADDR_W-1:2], bridge_data};
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      full_q        <= 1'b0;
      download_q    <= 1'b0;
      end_pending_q <= 1'b0;
      overflow_q    <= 1'b0;
      index_q       <= '0;
      state_q       <= S_EMPTY;
      gap_q         <= '0;
      word_addr_q   <= '0;
      word_data_q   <= '0;
      byte_cnt_q    <= '0;
      have_word_q   <= 1'b0;
      wr_q          <= 1'b0;
      addr_q        <= '0;
      dout_q        <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      count_q <= count_d;
      full_q  <= (count_d == FULL_CNT);

      if (!download_q) begin
        // A simultaneous dl_end is ignored while idle.
        if (dl_start) begin
          download_q <= 1'b1;
          index_q    <= bridge_index;
          overflow_q <= 1'b0;
        end
      end else begin
        if (drop)   overflow_q    <= 1'b1;
        if (dl_end) end_pending_q <= 1'b1;
        if (finish) begin
          download_q    <= 1'b0;
          end_pending_q <= 1'b0;
        end
      end

      wr_q <= 1'b0;
      if (pop) begin
        word_addr_q <= pop_entry[ENT_W-1:32];
        word_data_q <= pop_entry[31:0];
        byte_cnt_q  <= 2'd0;
        have_word_q <= 1'b1;
      end

      case (state_q)
        S_EMPTY: begin
          if (pop) state_q <= S_READY;
        end
        S_READY: begin
          if (issue) begin
            wr_q        <= 1'b1;
            addr_q      <= {word_addr_q, byte_cnt_q};
            dout_q      <= word_data_q[31:24];
            word_data_q <= {word_data_q[23:0], 8'h00};
            byte_cnt_q  <= byte_cnt_q + 2'd1;
            if (byte_cnt_q == 2'd3) have_word_q <= 1'b0;
            gap_q   <= GAP_INIT;
            state_q <= S_GAP;
          end
        end
        S_GAP: begin
          if (gap_q != '0) gap_q <= gap_q - GAP_ONE;
          // With a byte ready, leave as the counter reaches 0 so strobes are
          // exactly WRITE_GAP+1 apart. Otherwise wait out the 0 cycle, which
          // gives a late-arriving word one more chance to be popped.
          if ((gap_q == GAP_ONE) && (have_word_q || pop)) begin
            state_q <= S_READY;
          end else if (gap_q == '0) begin
            state_q <= (have_word_q || pop) ? S_READY : S_EMPTY;
          end
        end
        default: state_q <= S_EMPTY;
      endcase
    end
  end

  assign fifo_full      = full_q;
  assign overflow       = overflow_q;
  assign ioctl_download = download_q;
  assign ioctl_index    = index_q;
  assign ioctl_wr       = wr_q;
  assign ioctl_addr     = addr_q;
  assign ioctl_dout     = dout_q;

  // Address bits outside the word address are not stored.
  logic unused_addr_bits;
  if (ADDR_W < 32) begin : g_unused_hi
    assign unused_addr_bits = ^{bridge_addr[31:ADDR_W], bridge_addr[1:0]};
  end else begin : g_unused_lo
    assign unused_addr_bits = ^bridge_addr[1:0];
  end

endmodule

// File: tb/tb_bridge_ioctl_tx.sv
// Testbench for bridge_ioctl_tx: directed stimulus pushes expected bytes into
// a scoreboard queue; a negedge monitor pops and checks each ioctl_wr pulse.

module tb_bridge_ioctl_tx;

  localparam int FIFO_DEPTH = 16;
  localparam int WRITE_GAP  = 4;
  localparam int ADDR_W     = 25;

  logic              CLK = 1'b0;
  logic              RSTn = 1'b0;
  logic              dl_start = 1'b0;
  logic              dl_end = 1'b0;
  logic [7:0]        bridge_index = '0;
  logic              bridge_wr = 1'b0;
  logic [31:0]       bridge_addr = '0;
  logic [31:0]       bridge_data = '0;
  logic              ioctl_wait = 1'b0;
  logic              fifo_full;
  logic              overflow;
  logic              ioctl_download;
  logic [7:0]        ioctl_index;
  logic              ioctl_wr;
  logic [ADDR_W-1:0] ioctl_addr;
  logic [7:0]        ioctl_dout;

  bridge_ioctl_tx #(
    .FIFO_DEPTH(FIFO_DEPTH),
    .WRITE_GAP (WRITE_GAP),
    .ADDR_W    (ADDR_W)
  ) dut (
    .CLK           (CLK),
    .RSTn          (RSTn),
    .dl_start      (dl_start),
    .dl_end        (dl_end),
    .bridge_index  (bridge_index),
    .bridge_wr     (bridge_wr),
    .bridge_addr   (bridge_addr),
    .bridge_data   (bridge_data),
    .fifo_full     (fifo_full),
    .overflow      (overflow),
    .ioctl_download(ioctl_download),
    .ioctl_index   (ioctl_index),
    .ioctl_wr      (ioctl_wr),
    .ioctl_addr    (ioctl_addr),
    .ioctl_dout    (ioctl_dout),
    .ioctl_wait    (ioctl_wait)
  );

  always #5 CLK = ~CLK;

  // cyc = index of the most recent rising edge
  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [7:0]        data;
    int                cyc;   // -1: timing not checked
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   tests = 0;
  int   fails = 0;
  int   pulses = 0;
  int   last_pulse = -1;
  logic prev_wr = 1'b0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Monitor / scoreboard checker
  always @(negedge CLK) begin
    if (!RSTn) begin
      prev_wr    = 1'b0;
      last_pulse = -1;
    end else begin
      if (ioctl_wr) begin
        pulses++;
        $display("[TB] byte cycle %0d addr 0x%0h dout 0x%02h", cyc, ioctl_addr, ioctl_dout);
        chk("no_consecutive_wr", prev_wr, 1'b0);
        chk("download_high_at_pulse", ioctl_download, 1'b1);
        if (last_pulse >= 0) chk("min_pulse_spacing", (cyc - last_pulse) >= WRITE_GAP + 1, 1'b1);
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_pulse: got addr 0x%0h dout 0x%0h, expected no pulse", ioctl_addr, ioctl_dout);
        end else begin
          mon_e = sb.pop_front();
          chk("byte_addr", ioctl_addr, mon_e.addr);
          chk("byte_data", ioctl_dout, mon_e.data);
          if (mon_e.cyc >= 0) chk("pulse_cycle", cyc, mon_e.cyc);
        end
        last_pulse = cyc;
      end
      prev_wr = ioctl_wr;
    end
  end

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic wr_word(input logic [31:0] a, input logic [31:0] d);
    bridge_addr = a;
    bridge_data = d;
    bridge_wr   = 1'b1;
    tick();
    bridge_wr   = 1'b0;
  endtask

  task automatic exp_byte(input logic [ADDR_W-1:0] a, input logic [7:0] d, input int c);
    exp_t e;
    e.addr = a;
    e.data = d;
    e.cyc  = c;
    sb.push_back(e);
  endtask

  task automatic exp_word(input logic [31:0] a, input logic [31:0] d);
    logic [ADDR_W-1:0] base;
    logic [31:0]       t;
    base = a[ADDR_W-1:0];
    base[1:0] = 2'b00;
    for (int k = 0; k < 4; k++) begin
      t = d << (8 * k);
      exp_byte(base + ADDR_W'(k), t[31:24], -1);
    end
  endtask

  task automatic wait_drain(input string name);
    int g;
    g = 0;
    while (sb.size() != 0 && g < 3000) begin
      tick();
      g++;
    end
    chk(name, sb.size(), 0);
    repeat (20) tick();
  endtask

  task automatic wait_dl_low(input string name);
    int g;
    g = 0;
    while (ioctl_download && g < 500) begin
      tick();
      g++;
    end
    chk(name, ioctl_download, 1'b0);
  endtask

  task automatic chk_all_zero(input string pfx);
    chk({pfx, "_fifo_full"}, fifo_full, 1'b0);
    chk({pfx, "_overflow"}, overflow, 1'b0);
    chk({pfx, "_download"}, ioctl_download, 1'b0);
    chk({pfx, "_index"}, ioctl_index, 8'h00);
    chk({pfx, "_wr"}, ioctl_wr, 1'b0);
    chk({pfx, "_addr"}, ioctl_addr, '0);
    chk({pfx, "_dout"}, ioctl_dout, 8'h00);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int p0;
    int fall;
    logic [31:0] d;

    // Reset state
    RSTn = 1'b0;
    repeat (3) tick();
    chk_all_zero("reset");
    RSTn = 1'b1;
    tick();

    // Write while idle: ignored, no pulses, overflow untouched
    wr_word(32'h0000_0040, 32'h1122_3344);
    repeat (15) tick();
    chk("idle_write_overflow", overflow, 1'b0);
    chk("idle_write_download", ioctl_download, 1'b0);

    // Index capture; a second start while active is ignored
    bridge_index = 8'd3; dl_start = 1'b1; tick(); dl_start = 1'b0;
    chk("download_started", ioctl_download, 1'b1);
    chk("index_captured", ioctl_index, 8'd3);
    bridge_index = 8'd5; dl_start = 1'b1; tick(); dl_start = 1'b0;
    tick();
    chk("second_start_ignored", ioctl_index, 8'd3);

    // Empty download end: falls one edge after dl_end is sampled
    dl_end = 1'b1; tick(); dl_end = 1'b0;
    chk("download_high_at_end_edge", ioctl_download, 1'b1);
    tick();
    chk("download_low_after_empty_end", ioctl_download, 1'b0);
    chk("index_held_after_end", ioctl_index, 8'd3);

    // Start and end in the same idle cycle: only the start takes effect
    bridge_index = 8'd0; dl_start = 1'b1; dl_end = 1'b1; tick();
    dl_start = 1'b0; dl_end = 1'b0;
    chk("start_with_end_opens", ioctl_download, 1'b1);
    repeat (3) tick();
    chk("start_with_end_stays_open", ioctl_download, 1'b1);
    chk("index_zero", ioctl_index, 8'd0);

    // Single word: pulses at N+2, N+7, N+12, N+17
    n = cyc + 1;
    exp_byte(25'h100, 8'hA1, n + 2);
    exp_byte(25'h101, 8'hB2, n + 7);
    exp_byte(25'h102, 8'hC3, n + 12);
    exp_byte(25'h103, 8'hD4, n + 17);
    wr_word(32'h0000_0100, 32'hA1B2_C3D4);
    wait_drain("single_word_drain");

    // Stall: wait sampled high at edges N+6..N+14, second pulse at N+15
    n = cyc + 1;
    exp_byte(25'h100, 8'hA1, n + 2);
    exp_byte(25'h101, 8'hB2, n + 15);
    exp_byte(25'h102, 8'hC3, n + 20);
    exp_byte(25'h103, 8'hD4, n + 25);
    p0 = pulses;
    wr_word(32'h0000_0100, 32'hA1B2_C3D4);
    while (cyc < n + 5) tick();
    ioctl_wait = 1'b1;
    while (cyc < n + 14) tick();
    ioctl_wait = 1'b0;
    wait_drain("stall_drain");
    chk("stall_pulse_count", pulses - p0, 4);

    // Overflow: 18 writes while stalled, 17 words kept, 18th dropped
    ioctl_wait = 1'b1;
    p0 = pulses;
    for (int i = 0; i < 18; i++) begin
      d = {8'(i), 8'h5A, 8'(i) ^ 8'hFF, 8'hC3};
      if (i == 16) chk("not_full_before_17th", fifo_full, 1'b0);
      if (i == 17) begin
        chk("full_at_18th", fifo_full, 1'b1);
        chk("no_overflow_before_18th", overflow, 1'b0);
      end
      if (i < 17) exp_word(32'h0000_1000 + 32'(4 * i), d);
      wr_word(32'h0000_1000 + 32'(4 * i), d);
    end
    chk("overflow_set", overflow, 1'b1);
    chk("full_after_drop", fifo_full, 1'b1);
    repeat (5) tick();
    ioctl_wait = 1'b0;
    wait_drain("overflow_drain");
    chk("overflow_pulse_count", pulses - p0, 68);
    chk("overflow_sticky", overflow, 1'b1);
    dl_end = 1'b1; tick(); dl_end = 1'b0;
    wait_dl_low("overflow_download_closes");

    // End drain: 3 words then dl_end; writes after dl_end are ignored
    bridge_index = 8'd7; dl_start = 1'b1; tick(); dl_start = 1'b0;
    chk("overflow_cleared_on_start", overflow, 1'b0);
    chk("index_seven", ioctl_index, 8'd7);
    p0 = pulses;
    exp_word(32'h0000_3000, 32'h0102_0304);
    exp_word(32'h0000_3004, 32'h1122_3344);
    exp_word(32'h0000_3008, 32'hDEAD_BEEF);
    wr_word(32'h0000_3000, 32'h0102_0304);
    wr_word(32'h0000_3004, 32'h1122_3344);
    wr_word(32'h0000_3008, 32'hDEAD_BEEF);
    dl_end = 1'b1; tick(); dl_end = 1'b0;
    wr_word(32'h0000_3F00, 32'hFFFF_FFFF);
    wait_dl_low("end_drain_download_low");
    fall = cyc;
    chk("end_drain_pulse_count", pulses - p0, 12);
    chk("end_drain_all_bytes", sb.size(), 0);
    chk("download_fall_cycle", fall, last_pulse + WRITE_GAP + 2);
    chk("index_held_after_drain", ioctl_index, 8'd7);
    repeat (20) tick();
    chk("no_pulse_after_end", pulses - p0, 12);

    // Reset mid-stream after 5 of 8 bytes
    bridge_index = 8'd9; dl_start = 1'b1; tick(); dl_start = 1'b0;
    p0 = pulses;
    exp_word(32'h0000_0500, 32'hAABB_CCDD);
    exp_word(32'h0000_0504, 32'hEEFF_0011);
    wr_word(32'h0000_0500, 32'hAABB_CCDD);
    wr_word(32'h0000_0504, 32'hEEFF_0011);
    begin
      int g;
      g = 0;
      while (pulses < p0 + 5 && g < 200) begin
        tick();
        g++;
      end
    end
    chk("five_bytes_before_reset", pulses - p0, 5);
    RSTn = 1'b0;
    #1;
    chk_all_zero("midreset");
    sb.delete();
    repeat (3) tick();
    RSTn = 1'b1;
    p0 = pulses;
    repeat (40) tick();
    chk("no_pulse_after_reset", pulses - p0, 0);
    chk("download_low_after_reset", ioctl_download, 1'b0);

    // Fresh download after reset
    bridge_index = 8'd2; dl_start = 1'b1; tick(); dl_start = 1'b0;
    n = cyc + 1;
    exp_byte(25'h600, 8'h12, n + 2);
    exp_byte(25'h601, 8'h34, n + 7);
    exp_byte(25'h602, 8'h56, n + 12);
    exp_byte(25'h603, 8'h78, n + 17);
    wr_word(32'h0000_0600, 32'h1234_5678);
    wait_drain("post_reset_drain");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/bridge_ioctl_tx.md
# bridge_ioctl_tx

Transmitter side of the core's ioctl download stream. Accepts 32-bit word writes from the Pocket APF bridge into a small FIFO and serialises them into the byte-wide `ioctl_*` stream that `rom_loader` consumes. Paces bytes so the SDRAM/BRAM writer can keep up, and honours `ioctl_wait` backpressure. Sits between the APF bridge clock-domain crossing (already in CLK) and `rom_loader` inside `xain_top`.

## Interface
- `FIFO_DEPTH`, 16: word entries; power of two, ≥2.
- `WRITE_GAP`, 4: minimum idle cycles between `ioctl_wr` pulses; ≥1.
- `ADDR_W`, 25: width of `ioctl_addr`.

Ports:
- `CLK`  in  1  single clock, rising edge.
- `RSTn`  in  1  asynchronous, active-low reset.
- `dl_start`  in  1  1-cycle pulse; opens a download and captures `bridge_index`.
- `dl_end`  in  1  1-cycle pulse; host has sent its last word.
- `bridge_index`  in  8  dataslot number; becomes `ioctl_index`.
- `bridge_wr`  in  1  1-cycle strobe; one word write.
- `bridge_addr`  in  32  byte address of the word; bits [1:0] are ignored.
- `bridge_data`  in  32  word, big-endian.
- `fifo_full`  out  1  FIFO holds `FIFO_DEPTH` words.
- `overflow`  out  1  sticky; a write was dropped because the FIFO was full.
- `ioctl_download`  out  1  download in progress.
- `ioctl_index`  out  8  captured index.
- `ioctl_wr`  out  1  1-cycle byte strobe.
- `ioctl_addr`  out  `ADDR_W`  byte address, valid with `ioctl_wr` and held until the next pulse.
- `ioctl_dout`  out  8  byte data, same validity as `ioctl_addr`.
- `ioctl_wait`  in  1  receiver stall request.

## Operation
- Reset: all outputs are 0, the FIFO is empty, the shift register is empty, end_pending is 0 and the gap counter is 0.
- Download control:
  - `dl_start` while `ioctl_download`=0: `ioctl_download`←1, `ioctl_index`←`bridge_index`, `overflow`←0.
  - `dl_start` while active: ignored.
  - `dl_end` while idle: ignored. If `dl_start` and `dl_end` arrive in the same idle cycle, only the start takes effect.
  - `dl_end` while active: sets end_pending. `bridge_wr` is ignored from that cycle on.
- FIFO:
  - An entry is {`bridge_addr`[ADDR_W-1:2], `bridge_data`}.
  - Push on `bridge_wr` when `ioctl_download`=1, end_pending=0 and `fifo_full`=0.
  - `bridge_wr` while full is dropped and sets `overflow`. This holds even if a pop happens in the same cycle.
  - `bridge_wr` while idle is silently ignored; `overflow` is unchanged.
  - Pointers wrap modulo `FIFO_DEPTH`. The count is `log2(FIFO_DEPTH)+1` bits wide.
- Serialiser FSM:
  - State EMPTY: no word held. If the FIFO is non-empty, pop into the shift register with byte count 0 and go to READY.
  - State READY: a byte is pending. Issue `ioctl_wr` when `ioctl_wait`=0 and the gap counter is 0, then go to GAP.
  - State GAP: the gap counter counts down from `WRITE_GAP`. At 0, go to READY if bytes remain; otherwise go to EMPTY, or directly to READY if a new word was popped.
  - Prefetch: when the 4th byte is emitted and the FIFO is non-empty, the next word is popped during GAP. Word boundaries therefore add no extra spacing.
- Byte order: byte k (k=0..3) is `data`[31-8k:24-8k] at address {word_addr, k[1:0]}.
- `ioctl_wait` is sampled only in READY. It never truncates, repeats or reorders a byte.
- End of download: `ioctl_download`←0 on the cycle after all of these hold: end_pending=1, FIFO empty, serialiser in EMPTY, gap counter 0. end_pending is cleared at the same time.
- Asserting `RSTn` low mid-download clears everything at once. Queued data is discarded.

## Timing
- Latency: a `bridge_wr` sampled at edge N, into an empty FIFO with the serialiser idle and `ioctl_wait`=0, produces its first `ioctl_wr` high during cycle N+2.
- Pulse spacing is exactly `WRITE_GAP`+1 cycles when there are no stalls, both within a word and across word boundaries. With `ioctl_wait`=1, the pulse is issued in the first cycle after `ioctl_wait` falls.
- `fifo_full` is registered and reflects the count after the current edge.
- `ioctl_wr` is never high for two consecutive cycles.

## Test plan
- Single word: `dl_start` (index 0), write 0x100 / 0xA1B2C3D4, `WRITE_GAP`=4 → pulses at N+2, N+7, N+12, N+17 with addresses 0x100–0x103 and data A1, B2, C3, D4.
- Stall: hold `ioctl_wait` high for cycles N+5…N+14 → the second pulse occurs at N+15 with B2 at 0x101; exactly 4 pulses in total.
- Overflow: `ioctl_wait`=1, then 18 back-to-back writes with `FIFO_DEPTH`=16 → `fifo_full`=1 while the 18th arrives, that write is dropped and `overflow`=1. Release `ioctl_wait` → exactly 68 pulses in address order.
- End drain: 3 words queued, then `dl_end` → `ioctl_download` stays high through 12 pulses, falls `WRITE_GAP`+2 cycles after the last pulse, and `ioctl_index` is held.
- Index and ignored writes: `bridge_wr` while idle → no pulses, `overflow`=0. `dl_start` with index 3 → `ioctl_index`=3; a second `dl_start` with index 5 while active is ignored.
- Reset mid-stream: drop `RSTn` after 5 of 8 bytes → all outputs 0 immediately. After release, no pulses occur until a new `dl_start` and write.
